// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle for id_ex_stage: decode fields, writeback snoop,
// pipeline controls and the registered execute-side view.
interface id_ex_stage_if #(
   parameter int CTRL_W = 12
) ();
   logic              stall;
   logic              flush;
   logic              id_valid;
   logic [31:0]       id_pc;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [4:0]        id_dst;
   logic [31:0]       id_imm;
   logic [31:0]       id_rs_data;
   logic [31:0]       id_rt_data;
   logic [CTRL_W-1:0] id_ctrl;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              wb_reg_write;
   logic [4:0]        wb_write_reg;
   logic [31:0]       wb_write_data;
   logic              ex_valid;
   logic [31:0]       ex_pc;
   logic [4:0]        ex_rs;
   logic [4:0]        ex_rt;
   logic [4:0]        ex_dst;
   logic [31:0]       ex_imm;
   logic [31:0]       ex_rs_data;
   logic [31:0]       ex_rt_data;
   logic [CTRL_W-1:0] ex_ctrl;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              hazard_stall;

   modport master (
      output stall, flush, id_valid, id_pc, id_rs, id_rt, id_dst, id_imm,
             id_rs_data, id_rt_data, id_ctrl, id_reg_write, id_mem_read,
             wb_reg_write, wb_write_reg, wb_write_data,
      input  ex_valid, ex_pc, ex_rs, ex_rt, ex_dst, ex_imm, ex_rs_data,
             ex_rt_data, ex_ctrl, ex_reg_write, ex_mem_read, hazard_stall
   );

   modport slave (
      input  stall, flush, id_valid, id_pc, id_rs, id_rt, id_dst, id_imm,
             id_rs_data, id_rt_data, id_ctrl, id_reg_write, id_mem_read,
             wb_reg_write, wb_write_reg, wb_write_data,
      output ex_valid, ex_pc, ex_rs, ex_rt, ex_dst, ex_imm, ex_rs_data,
             ex_rt_data, ex_ctrl, ex_reg_write, ex_mem_read, hazard_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, held-operand
// refresh during stalls, and load-use bubble insertion.
module id_ex_stage #(
   parameter int CTRL_W = 12
) (
   input logic          clk,
   input logic          rst_n,
   id_ex_stage_if.slave bus
);

   // Register-file write lands on the same edge, so the combinational read is stale on a hit.
   function automatic logic [31:0] bypass_op(input logic [4:0]  idx,
                                             input logic [31:0] rf_data,
                                             input logic        wen,
                                             input logic [4:0]  widx,
                                             input logic [31:0] wdata);
      logic [31:0] res;
      if (idx == 5'd0) begin
         res = 32'd0;
      end else if (wen && (widx == idx)) begin
         res = wdata;
      end else begin
         res = rf_data;
      end
      return res;
   endfunction

   function automatic logic wb_hits(input logic [4:0] idx,
                                    input logic       wen,
                                    input logic [4:0] widx);
      return wen && (widx != 5'd0) && (widx == idx);
   endfunction

   logic              ex_valid_r;
   logic [31:0]       ex_pc_r;
   logic [4:0]        ex_rs_r;
   logic [4:0]        ex_rt_r;
   logic [4:0]        ex_dst_r;
   logic [31:0]       ex_imm_r;
   logic [31:0]       ex_rs_data_r;
   logic [31:0]       ex_rt_data_r;
   logic [CTRL_W-1:0] ex_ctrl_r;
   logic              ex_reg_write_r;
   logic              ex_mem_read_r;

   logic [31:0]       op1_s;
   logic [31:0]       op2_s;
   logic              hazard_s;

   // Bypassed operands and load-use detection against the load sitting in execute.
   always_comb begin
      op1_s    = bypass_op(bus.id_rs, bus.id_rs_data, bus.wb_reg_write,
                           bus.wb_write_reg, bus.wb_write_data);
      op2_s    = bypass_op(bus.id_rt, bus.id_rt_data, bus.wb_reg_write,
                           bus.wb_write_reg, bus.wb_write_data);
      hazard_s = 1'b0;
      if (bus.id_valid && ex_valid_r && ex_mem_read_r && (ex_dst_r != 5'd0) &&
          ((ex_dst_r == bus.id_rs) || (ex_dst_r == bus.id_rt)) &&
          !bus.flush && !bus.stall) begin
         hazard_s = 1'b1;
      end else begin
         hazard_s = 1'b0;
      end
   end

   // Stage register: flush > stall (with operand refresh) > hazard bubble > load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_r     <= 1'b0;
         ex_pc_r        <= 32'd0;
         ex_rs_r        <= 5'd0;
         ex_rt_r        <= 5'd0;
         ex_dst_r       <= 5'd0;
         ex_imm_r       <= 32'd0;
         ex_rs_data_r   <= 32'd0;
         ex_rt_data_r   <= 32'd0;
         ex_ctrl_r      <= {CTRL_W{1'b0}};
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
      end else if (bus.flush || hazard_s) begin
         ex_valid_r     <= 1'b0;
         ex_ctrl_r      <= {CTRL_W{1'b0}};
         ex_reg_write_r <= 1'b0;
         ex_mem_read_r  <= 1'b0;
      end else if (bus.stall) begin
         if (wb_hits(ex_rs_r, bus.wb_reg_write, bus.wb_write_reg)) begin
            ex_rs_data_r <= bus.wb_write_data;
         end
         if (wb_hits(ex_rt_r, bus.wb_reg_write, bus.wb_write_reg)) begin
            ex_rt_data_r <= bus.wb_write_data;
         end
      end else begin
         ex_valid_r     <= bus.id_valid;
         ex_pc_r        <= bus.id_pc;
         ex_rs_r        <= bus.id_rs;
         ex_rt_r        <= bus.id_rt;
         ex_dst_r       <= bus.id_dst;
         ex_imm_r       <= bus.id_imm;
         ex_rs_data_r   <= op1_s;
         ex_rt_data_r   <= op2_s;
         ex_ctrl_r      <= bus.id_ctrl;
         ex_reg_write_r <= bus.id_reg_write & bus.id_valid;
         ex_mem_read_r  <= bus.id_mem_read & bus.id_valid;
      end
   end

   assign bus.ex_valid     = ex_valid_r;
   assign bus.ex_pc        = ex_pc_r;
   assign bus.ex_rs        = ex_rs_r;
   assign bus.ex_rt        = ex_rt_r;
   assign bus.ex_dst       = ex_dst_r;
   assign bus.ex_imm       = ex_imm_r;
   assign bus.ex_rs_data   = ex_rs_data_r;
   assign bus.ex_rt_data   = ex_rt_data_r;
   assign bus.ex_ctrl      = ex_ctrl_r;
   assign bus.ex_reg_write = ex_reg_write_r;
   assign bus.ex_mem_read  = ex_mem_read_r;
   assign bus.hazard_stall = hazard_s;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a register-file model feeds decode, and the
// expected execute contents are derived from the architectural register values.
module tb_id_ex_stage;

   localparam int CTRL_W = 12;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] imm;
      logic [11:0] ctrl;
      logic        rw;
      logic        mr;
      logic        stall;
      logic        flush;
      logic        wen;
      logic [4:0]  wreg;
      logic [31:0] wdata;
   } stim_t;

   typedef struct packed {
      logic        full;
      logic        valid;
      logic [31:0] pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] imm;
      logic [11:0] ctrl;
      logic        rw;
      logic        mr;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
   } exp_t;

   logic clk;
   logic rst_n;
   id_ex_stage_if #(.CTRL_W(CTRL_W)) bus ();

   id_ex_stage #(.CTRL_W(CTRL_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] regs [32];
   exp_t        mdl;
   exp_t        eq [$];
   logic        hq [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      return s;
   endfunction

   function automatic stim_t rand_stim();
      stim_t s;
      s.valid = ($urandom_range(7, 0) != 32'd0);
      s.pc    = $urandom;
      s.rs    = 5'($urandom_range(7, 0));
      s.rt    = 5'($urandom_range(7, 0));
      s.dst   = 5'($urandom_range(7, 0));
      s.imm   = $urandom;
      s.ctrl  = 12'($urandom);
      s.rw    = 1'($urandom_range(1, 0));
      s.mr    = ($urandom_range(2, 0) == 32'd0);
      s.stall = ($urandom_range(5, 0) == 32'd0);
      s.flush = ($urandom_range(9, 0) == 32'd0);
      s.wen   = 1'($urandom_range(1, 0));
      s.wreg  = 5'($urandom_range(7, 0));
      s.wdata = $urandom;
      return s;
   endfunction

   task automatic zero_inputs();
      bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
      bus.id_pc = 32'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_dst = 5'd0;
      bus.id_imm = 32'd0; bus.id_rs_data = 32'd0; bus.id_rt_data = 32'd0;
      bus.id_ctrl = 12'd0; bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0;
      bus.wb_reg_write = 1'b0; bus.wb_write_reg = 5'd0; bus.wb_write_data = 32'd0;
   endtask

   // Drive one decode cycle and record what execute must hold after the edge.
   task automatic cycle(input stim_t s, output logic hz);
      @(negedge clk);
      bus.stall         = s.stall;
      bus.flush         = s.flush;
      bus.id_valid      = s.valid;
      bus.id_pc         = s.pc;
      bus.id_rs         = s.rs;
      bus.id_rt         = s.rt;
      bus.id_dst        = s.dst;
      bus.id_imm        = s.imm;
      bus.id_rs_data    = (s.rs == 5'd0) ? $urandom : regs[s.rs];
      bus.id_rt_data    = (s.rt == 5'd0) ? $urandom : regs[s.rt];
      bus.id_ctrl       = s.ctrl;
      bus.id_reg_write  = s.rw;
      bus.id_mem_read   = s.mr;
      bus.wb_reg_write  = s.wen;
      bus.wb_write_reg  = s.wreg;
      bus.wb_write_data = s.wdata;

      hz = s.valid && mdl.valid && mdl.mr && (mdl.dst != 5'd0) &&
           ((mdl.dst == s.rs) || (mdl.dst == s.rt)) && !s.flush && !s.stall;
      hq.push_back(hz);

      if (s.wen && (s.wreg != 5'd0)) regs[s.wreg] = s.wdata;

      if (s.flush || hz) begin
         mdl.full = 1'b0; mdl.valid = 1'b0; mdl.rw = 1'b0; mdl.mr = 1'b0; mdl.ctrl = 12'd0;
      end else if (s.stall) begin
         mdl.rs_data = regs[mdl.rs];
         mdl.rt_data = regs[mdl.rt];
      end else begin
         mdl.full    = 1'b1;
         mdl.valid   = s.valid;
         mdl.pc      = s.pc;
         mdl.rs      = s.rs;
         mdl.rt      = s.rt;
         mdl.dst     = s.dst;
         mdl.imm     = s.imm;
         mdl.ctrl    = s.ctrl;
         mdl.rw      = s.rw & s.valid;
         mdl.mr      = s.mr & s.valid;
         mdl.rs_data = regs[s.rs];
         mdl.rt_data = regs[s.rt];
      end
      eq.push_back(mdl);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: hazard_stall is checked mid-low-phase, execute contents just after the edge.
   initial begin
      logic h;
      forever begin
         @(negedge clk);
         #2;
         if (hq.size() > 0) begin
            h = hq.pop_front();
            chk("hazard_stall", 32'(bus.hazard_stall), 32'(h));
         end
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("ex_valid", 32'(bus.ex_valid), 32'(e.valid));
            chk("ex_reg_write", 32'(bus.ex_reg_write), 32'(e.rw));
            chk("ex_mem_read", 32'(bus.ex_mem_read), 32'(e.mr));
            chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(e.ctrl));
            if (e.full) begin
               chk("ex_pc", bus.ex_pc, e.pc);
               chk("ex_rs", 32'(bus.ex_rs), 32'(e.rs));
               chk("ex_rt", 32'(bus.ex_rt), 32'(e.rt));
               chk("ex_dst", 32'(bus.ex_dst), 32'(e.dst));
               chk("ex_imm", bus.ex_imm, e.imm);
               chk("ex_rs_data", bus.ex_rs_data, e.rs_data);
               chk("ex_rt_data", bus.ex_rt_data, e.rt_data);
            end
         end
      end
   end

   initial begin
      stim_t s;
      stim_t prev;
      logic  hz;
      logic  last_hz;

      rst_n = 1'b0;
      zero_inputs();
      regs[0] = 32'd0;
      for (int i = 1; i < 32; i++) regs[i] = $urandom;
      mdl = '0;
      mdl.full = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      chk("rst_ex_pc", bus.ex_pc, 32'd0);
      chk("rst_ex_ctrl", 32'(bus.ex_ctrl), 32'd0);
      chk("rst_hazard", 32'(bus.hazard_stall), 32'd0);

      // Two loads, then an asynchronous reset in the middle of the high phase.
      s = nop(); s.valid = 1'b1; s.pc = 32'h0000_0100; s.rs = 5'd1; s.rt = 5'd2;
      s.dst = 5'd3; s.rw = 1'b1; s.ctrl = 12'hABC; s.imm = 32'h0000_0010;
      cycle(s, hz);
      s.pc = 32'h0000_0104;
      cycle(s, hz);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.ex_valid), 32'd0);
      chk("async_rst_pc", bus.ex_pc, 32'd0);
      chk("async_rst_rs_data", bus.ex_rs_data, 32'd0);
      chk("async_rst_ctrl", 32'(bus.ex_ctrl), 32'd0);
      chk("async_rst_rw", 32'(bus.ex_reg_write), 32'd0);
      mdl = '0;
      mdl.full = 1'b1;
      zero_inputs();
      @(negedge clk);
      rst_n = 1'b1;

      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_0000;
      cycle(s, hz);
      after_edge();
      chk("first_load_pc", bus.ex_pc, 32'h0040_0000);
      chk("first_load_valid", 32'(bus.ex_valid), 32'd1);

      // Writeback bypass, including the zero register.
      regs[8] = 32'h1111_1111;
      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_0004; s.rs = 5'd8;
      s.wen = 1'b1; s.wreg = 5'd8; s.wdata = 32'hDEAD_BEEF;
      cycle(s, hz);
      after_edge();
      chk("bypass_rs", bus.ex_rs_data, 32'hDEAD_BEEF);
      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_0008; s.rs = 5'd0;
      s.wen = 1'b1; s.wreg = 5'd0; s.wdata = 32'h1234_5678;
      cycle(s, hz);
      after_edge();
      chk("bypass_r0", bus.ex_rs_data, 32'd0);

      // Load-use pair: one bubble, then the consumer is captured.
      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_000C; s.rs = 5'd2; s.dst = 5'd9;
      s.mr = 1'b1; s.rw = 1'b1;
      cycle(s, hz);
      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_0010; s.rs = 5'd1; s.rt = 5'd9;
      s.dst = 5'd10; s.rw = 1'b1;
      cycle(s, hz);
      #3;
      chk("load_use_hazard", 32'(bus.hazard_stall), 32'd1);
      after_edge();
      chk("load_use_bubble", 32'(bus.ex_valid), 32'd0);
      cycle(s, hz);
      #3;
      chk("load_use_release", 32'(bus.hazard_stall), 32'd0);
      after_edge();
      chk("load_use_capture", bus.ex_pc, 32'h0040_0010);

      // Multi-cycle stall with a writeback to the held rt in the middle cycle.
      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_0014; s.rs = 5'd6; s.rt = 5'd5;
      s.dst = 5'd7; s.rw = 1'b1; s.ctrl = 12'h5A5;
      cycle(s, hz);
      s = nop(); s.stall = 1'b1;
      cycle(s, hz);
      s.wen = 1'b1; s.wreg = 5'd5; s.wdata = 32'h0000_0042;
      cycle(s, hz);
      after_edge();
      chk("stall_refresh", bus.ex_rt_data, 32'h0000_0042);
      s.wen = 1'b0;
      cycle(s, hz);
      after_edge();
      chk("stall_hold_pc", bus.ex_pc, 32'h0040_0014);

      // Flush beats stall.
      s = nop(); s.valid = 1'b1; s.pc = 32'h0040_0018; s.rw = 1'b1;
      s.flush = 1'b1; s.stall = 1'b1;
      cycle(s, hz);
      after_edge();
      chk("flush_valid", 32'(bus.ex_valid), 32'd0);
      chk("flush_rw", 32'(bus.ex_reg_write), 32'd0);

      // Back-to-back stream with no hazards.
      for (int i = 0; i < 8; i++) begin
         s = nop(); s.valid = 1'b1; s.pc = 32'h0000_1000 + 32'(4 * i);
         s.rs = 5'(i + 1); s.rt = 5'(i + 2); s.dst = 5'(20 + i); s.rw = 1'b1;
         s.imm = 32'(i); s.ctrl = 12'(i * 3);
         cycle(s, hz);
      end

      // Random traffic; a hazarded decode instruction is re-presented.
      last_hz = 1'b0;
      prev = nop();
      for (int n = 0; n < 500; n++) begin
         s = rand_stim();
         if (last_hz) begin
            s.valid = prev.valid; s.pc = prev.pc; s.rs = prev.rs; s.rt = prev.rt;
            s.dst = prev.dst; s.imm = prev.imm; s.ctrl = prev.ctrl;
            s.rw = prev.rw; s.mr = prev.mr;
         end
         cycle(s, hz);
         last_hz = hz;
         prev = s;
      end

      repeat (3) @(negedge clk);
      chk("ex_queue_drained", 32'(eq.size()), 32'd0);
      chk("hz_queue_drained", 32'(hq.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between decode and execute.
- Captures the two register-file read operands, the decoded fields and the control bundle each cycle.
- Bypasses a same-cycle writeback into the captured operands. The register file writes on the clock edge and reads combinationally, so without this bypass a same-cycle read returns the stale value.
- Detects load-use hazards, inserts a bubble into execute and requests a decode/fetch hold.

Parameters:
- CTRL_W, 12, width of the opaque control bundle passed from decode to execute.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall  input  1  downstream hold; stage keeps all contents.
- flush  input  1  branch/exception kill; stage loads a bubble.
- id_valid  input  1  decode slot holds a real instruction.
- id_pc  input  32  instruction PC.
- id_rs  input  5  source register 1 index.
- id_rt  input  5  source register 2 index.
- id_dst  input  5  destination register index (0 = none).
- id_imm  input  32  sign/zero-extended immediate.
- id_rs_data  input  32  register-file read_data_1.
- id_rt_data  input  32  register-file read_data_2.
- id_ctrl  input  CTRL_W  control bundle.
- id_reg_write  input  1  instruction writes id_dst.
- id_mem_read  input  1  instruction is a load.
- wb_reg_write  input  1  writeback enable, same signal driving the register file.
- wb_write_reg  input  5  writeback register index.
- wb_write_data  input  32  writeback data.
- ex_valid  output  1  execute slot valid.
- ex_pc  output  32  registered id_pc.
- ex_rs  output  5  registered id_rs.
- ex_rt  output  5  registered id_rt.
- ex_dst  output  5  registered id_dst.
- ex_imm  output  32  registered id_imm.
- ex_rs_data  output  32  registered operand 1.
- ex_rt_data  output  32  registered operand 2.
- ex_ctrl  output  CTRL_W  registered control bundle.
- ex_reg_write  output  1  registered write enable, gated by valid.
- ex_mem_read  output  1  registered load flag, gated by valid.
- hazard_stall  output  1  combinational; upstream must hold PC and IF/ID this cycle.

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_* outputs go to 0, including ex_valid, ex_ctrl and data. hazard_stall reads 0 because ex_valid=0.
- Operand bypass (combinational, before capture): the write hits when wb_reg_write=1, wb_write_reg!=0 and wb_write_reg equals the source index. On a hit:
  - op1 = wb_write_data if the hit is on id_rs, else id_rs_data.
  - op2 = wb_write_data if the hit is on id_rt, else id_rt_data.
  - Index 0 always yields 0, regardless of input data.
- Load-use hazard: hazard_stall = id_valid & ex_valid & ex_mem_read & (ex_dst!=0) & ((ex_dst==id_rs) | (ex_dst==id_rt)) & ~flush & ~stall.
- Edge update priority, evaluated at each posedge:
  1. flush=1: bubble. ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_ctrl=0; other fields don't-care (implementation: hold).
  2. stall=1: hold all fields, except that held operands are refreshed. If wb_reg_write=1, wb_write_reg!=0 and wb_write_reg==ex_rs, ex_rs_data takes wb_write_data. The same rule applies to ex_rt / ex_rt_data. This prevents stale operands across multi-cycle holds.
  3. hazard_stall=1: bubble as in priority 1. The decode instruction is re-presented next cycle by upstream.
  4. Otherwise: load. ex_valid=id_valid. ex_reg_write=id_reg_write&id_valid. ex_mem_read=id_mem_read&id_valid. All other fields take the id_* inputs and the bypassed op1/op2.
- Latency: one cycle from decode to ex_*. hazard_stall is asserted for exactly one cycle per load-use pair, because the bubble clears ex_mem_read.
- flush and stall high together: flush wins.
- Reset asserted mid-operation clears the stage immediately, without waiting for clk.
- No storage other than the ex_* registers.

Test Plan:
- Reset: drive rst_n low mid-cycle with ex_valid=1 -> all outputs 0 immediately; after release, first load captures id_pc=0x00400000 with ex_valid=1.
- Writeback bypass: id_rs=8, id_rs_data=0x11111111, wb_reg_write=1, wb_write_reg=8, wb_write_data=0xDEADBEEF -> next cycle ex_rs_data=0xDEADBEEF. Repeat with wb_write_reg=0 and id_rs=0 -> ex_rs_data=0.
- Load-use: cycle N loads lw with id_dst=9, id_mem_read=1. Cycle N+1 presents add with id_rt=9 -> hazard_stall=1 in N+1, ex_valid=0 after N+1 edge, and hazard_stall=0 in N+2 with the add captured.
- Stall with refresh: stage holds ex_rt=5, stall=1 for 3 cycles, wb writes reg 5 = 0x00000042 in cycle 2 -> ex_rt_data=0x00000042 after cycle 2 while all other fields remain unchanged.
- Flush priority: flush=1 with stall=1 and id_valid=1 -> ex_valid=0, ex_reg_write=0, hazard_stall=0.
- Back-to-back: 8 consecutive valid instructions with no hazards -> each appears on ex_* exactly one cycle later, in order, with no gaps.
